stream_mux_rr: RTL

Parametrised N-channel stream multiplexer with round-robin arbitration, valid/ready handshakes and a registered output stage; next generation of the team's fixed 8:1 combinational mux. Instead of an external select, it picks among requesting channels, forwards one beat per cycle, and tags each output beat with its source channel. Sits between multiple producer streams and a single shared consumer, such as a bus or serializer.

---
 rtl/stream_mux_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/stream_mux_rr.sv | 133 +++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared helpers for the round-robin stream multiplexer: width derivation and
// the arbitration-state encoding used when STREAM_MUX_RR_LOCK_EN is defined.
package stream_mux_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'sd1 <<< r) < n) begin
                r = r + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // A single-channel select still needs one bit to carry the index.
    function automatic int sel_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant selection starting at ptr, with an optional
// hold that restricts the grant to a single pinned channel.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             hold,
    input  logic [SEL_W-1:0] hold_ch,
    output logic [SEL_W-1:0] grant,
    output logic             any_grant
);

    // Pick the requester closest to ptr going upward modulo N, or only hold_ch.
    always_comb begin
        int  dist_s;
        int  best_s;
        logic take_s;
        grant     = {SEL_W{1'b0}};
        any_grant = 1'b0;
        best_s    = N;
        dist_s    = 0;
        take_s    = 1'b0;
        for (int i = 0; i < N; i++) begin
            dist_s = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N - int'(ptr));
            if (hold) begin
                take_s = req[i] && (hold_ch == SEL_W'(i));
            end else begin
                take_s = req[i] && (dist_s < best_s);
            end
            best_s    = take_s ? dist_s : best_s;
            grant     = take_s ? SEL_W'(i) : grant;
            any_grant = take_s | any_grant;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel round-robin stream mux with a registered output stage and source tag.
// Define STREAM_MUX_RR_LOCK_EN to keep the grant on one channel until its in_last beat.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    localparam int SEL_W = sel_w(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_last,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_last,
    input  logic                     out_ready
);

    logic              load_en_s;
    logic              xfer_s;
    logic              hold_s;
    logic [SEL_W-1:0]  hold_ch_s;
    logic [SEL_W-1:0]  grant_s;
    logic              any_grant_s;
    logic [SEL_W-1:0]  ptr_r;
    logic [SEL_W-1:0]  ptr_nxt_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              sel_last_s;

    assign load_en_s = !out_valid || out_ready;
    // rst_n gates the accept so no handshake completes while reset is held.
    assign xfer_s    = rst_n && load_en_s && any_grant_s;
    assign ptr_nxt_s = (grant_s == SEL_W'(N_CH - 1)) ? {SEL_W{1'b0}} : (grant_s + {{(SEL_W-1){1'b0}}, 1'b1});

    rr_arbiter #(
        .N     (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_r),
        .hold      (hold_s),
        .hold_ch   (hold_ch_s),
        .grant     (grant_s),
        .any_grant (any_grant_s)
    );

    // One-hot ready on the granted channel; data and last steered from the same index.
    always_comb begin
        logic hit_s;
        in_ready   = {N_CH{1'b0}};
        sel_data_s = {DATA_W{1'b0}};
        sel_last_s = 1'b0;
        hit_s      = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            hit_s       = (grant_s == SEL_W'(i));
            in_ready[i] = xfer_s && hit_s && in_valid[i];
            sel_data_s  = hit_s ? in_data[i*DATA_W +: DATA_W] : sel_data_s;
            sel_last_s  = hit_s ? in_last[i] : sel_last_s;
        end
    end

`ifdef STREAM_MUX_RR_LOCK_EN
    arb_state_t       state_r;
    logic [SEL_W-1:0] lock_ch_r;

    assign hold_s    = (state_r == LOCKED);
    assign hold_ch_s = lock_ch_r;

    // Packet-lock FSM; the pointer only moves when a packet's last beat is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ARB;
            lock_ch_r <= {SEL_W{1'b0}};
            ptr_r     <= {SEL_W{1'b0}};
        end else if (xfer_s) begin
            case (state_r)
                ARB, LOCKED: begin
                    if (sel_last_s) begin
                        state_r <= ARB;
                        ptr_r   <= ptr_nxt_s;
                    end else begin
                        state_r   <= LOCKED;
                        lock_ch_r <= grant_s;
                    end
                end
                default: begin
                    state_r <= ARB;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end
`else
    assign hold_s    = 1'b0;
    assign hold_ch_s = {SEL_W{1'b0}};

    // Per-beat round robin: advance past every granted channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {SEL_W{1'b0}};
        end else if (xfer_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

    // Output register: load on accept, drain when consumed, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= {DATA_W{1'b0}};
            out_ch    <= {SEL_W{1'b0}};
            out_last  <= 1'b0;
        end else if (xfer_s) begin
            out_valid <= 1'b1;
            out_data  <= sel_data_s;
            out_ch    <= grant_s;
            out_last  <= sel_last_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule
